wb_gcd_multi: RTL and testbench

WB_GCD_MULTI -- requirements
Module: wb_gcd_multi

---
 rtl/gcd_pkg.sv | 24 ++
 rtl/gcd_core.sv | 90 +++++++++
 rtl/wb_gcd_multi.sv | 143 ++++++++++++++
 tb/tb_wb_gcd_multi.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// gcd_pkg: register map, channel stride and channel state encoding shared by
// the Wishbone GCD block and its per-channel core.
package gcd_pkg;

    // Per-channel register offsets (low nibble of the channel window)
    localparam logic [3:0] REG_OPA    = 4'h0;
    localparam logic [3:0] REG_OPB    = 4'h4;
    localparam logic [3:0] REG_CTRL   = 4'h8;
    localparam logic [3:0] REG_RESULT = 4'hC;

    // Byte distance between consecutive channel register blocks
    localparam int CH_STRIDE = 16;

    // Shared interrupt registers
    localparam logic [8:0] OFF_IRQ_MASK = 9'h100;
    localparam logic [8:0] OFF_IRQ_STAT = 9'h104;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } gcd_state_e;

endpackage

// File: rtl/gcd_core.sv
// gcd_core: one GCD channel. Holds the programmed operands, a working pair
// reduced by subtract/swap one step per cycle, and the last result.
// Operand and start writes are ignored while a calculation is running.
module gcd_core
    import gcd_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_opa_i,
    input  logic             wr_opb_i,
    input  logic             start_i,
    input  logic             clr_done_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] opa_o,
    output logic [WIDTH-1:0] opb_o,
    output logic [WIDTH-1:0] result_o,
    output logic             busy_o,
    output logic             done_o
);

    gcd_state_e       state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;

    // State and datapath registers; reset aborts any calculation in flight
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

    // Next-state: accept programming when not busy, else run one reduction step
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        case (state_q)
            IDLE, DONE: begin
                if (wr_opa_i) opa_d = wdata_i;
                if (wr_opb_i) opb_d = wdata_i;
                if (start_i) begin
                    a_d     = opa_q;
                    b_d     = opb_q;
                    state_d = CALC;
                end else if (state_q == DONE && clr_done_i) begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (a_q < b_q) begin
                    a_d = b_q;
                    b_d = a_q;
                end else if (b_q != '0) begin
                    a_d = a_q - b_q;
                end else begin
                    res_d   = a_q;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign opa_o    = opa_q;
    assign opb_o    = opb_q;
    assign result_o = res_q;
    assign busy_o   = (state_q == CALC);
    assign done_o   = (state_q == DONE);

endmodule

// File: rtl/wb_gcd_multi.sv
// wb_gcd_multi: Wishbone slave exposing NCH independent GCD channels plus a
// shared interrupt mask/status pair. Single-cycle-latency ack, registered
// read data that is zero outside the ack cycle.
// Optional feature macro: GCD_IRQ_EN (enables IRQ_MASK and user_irq_o).
module wb_gcd_multi
    import gcd_pkg::*;
#(
    parameter int          WIDTH     = 32,
    parameter int          NCH       = 4,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        user_irq_o
);

    logic [8:0]       off_w;
    logic             in_win_w;
    logic             req_w;
    logic             wr_w;
    logic             ch_hit_w;
    logic [2:0]       ch_sel_w;
    logic [3:0]       reg_w;
    logic [31:0]      rdata_w;

    logic             ack_q, ack_d;
    logic [31:0]      dat_q, dat_d;
    logic             blk_q, blk_d;

    logic [WIDTH-1:0] opa_w [NCH];
    logic [WIDTH-1:0] opb_w [NCH];
    logic [WIDTH-1:0] res_w [NCH];
    logic [NCH-1:0]   busy_w, done_w;
    logic [NCH-1:0]   wr_opa_w, wr_opb_w, start_w, clr_w;
    logic [NCH-1:0]   mask_w;
    logic             unused_w;

    assign unused_w = ^{wbs_sel_i, wbs_adr_i[1:0], wbs_dat_i};

    assign off_w    = wbs_adr_i[8:0];
    assign in_win_w = (wbs_adr_i[31:9] == BASE_ADDR[31:9]);
    // blk_q suppresses a request still held from before reset release;
    // ack_q forbids back-to-back acks while the master drops strobe.
    assign req_w    = wbs_cyc_i & wbs_stb_i & in_win_w & ~ack_q & ~blk_q;
    assign wr_w     = req_w & wbs_we_i;
    assign ch_hit_w = (int'(off_w) < NCH * CH_STRIDE);
    assign ch_sel_w = off_w[6:4];
    assign reg_w    = {off_w[3:2], 2'b00};

    generate
        for (genvar c = 0; c < NCH; c++) begin : g_ch
            logic sel_w;
            assign sel_w       = wr_w & ch_hit_w & (ch_sel_w == 3'(c));
            assign wr_opa_w[c] = sel_w & (reg_w == REG_OPA);
            assign wr_opb_w[c] = sel_w & (reg_w == REG_OPB);
            assign start_w[c]  = sel_w & (reg_w == REG_CTRL) & wbs_dat_i[0];
            assign clr_w[c]    = wr_w & (off_w == OFF_IRQ_STAT) & wbs_dat_i[c];

            gcd_core #(.WIDTH(WIDTH)) u_core (
                .clk_i      (wb_clk_i),
                .rst_i      (wb_rst_i),
                .wr_opa_i   (wr_opa_w[c]),
                .wr_opb_i   (wr_opb_w[c]),
                .start_i    (start_w[c]),
                .clr_done_i (clr_w[c]),
                .wdata_i    (wbs_dat_i[WIDTH-1:0]),
                .opa_o      (opa_w[c]),
                .opb_o      (opb_w[c]),
                .result_o   (res_w[c]),
                .busy_o     (busy_w[c]),
                .done_o     (done_w[c])
            );
        end
    endgenerate

`ifdef GCD_IRQ_EN
    logic [NCH-1:0] mask_q, mask_d;

    // Interrupt mask register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) mask_q <= '0;
        else          mask_q <= mask_d;
    end

    assign mask_d     = (wr_w && off_w == OFF_IRQ_MASK) ? wbs_dat_i[NCH-1:0] : mask_q;
    assign mask_w     = mask_q;
    assign user_irq_o = |(done_w & mask_q);
`else
    assign mask_w     = '0;
    assign user_irq_o = 1'b0;
`endif

    // Read mux over channel registers and the interrupt pair; unmapped reads 0
    always_comb begin
        rdata_w = '0;
        if (ch_hit_w) begin
            for (int c = 0; c < NCH; c++) begin
                if (ch_sel_w == 3'(c)) begin
                    case (reg_w)
                        REG_OPA:    rdata_w = 32'(opa_w[c]);
                        REG_OPB:    rdata_w = 32'(opb_w[c]);
                        REG_CTRL:   rdata_w = {30'b0, done_w[c], busy_w[c]};
                        REG_RESULT: rdata_w = 32'(res_w[c]);
                        default:    rdata_w = '0;
                    endcase
                end
            end
        end else if (off_w == OFF_IRQ_MASK) begin
            rdata_w = 32'(mask_w);
        end else if (off_w == OFF_IRQ_STAT) begin
            rdata_w = 32'(done_w);
        end
    end

    assign ack_d = req_w;
    assign dat_d = (req_w && !wbs_we_i) ? rdata_w : 32'b0;
    assign blk_d = blk_q & wbs_cyc_i & wbs_stb_i;

    // Bus response registers; the block flag stays set until strobe drops
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q <= 1'b0;
            dat_q <= '0;
            blk_q <= 1'b1;
        end else begin
            ack_q <= ack_d;
            dat_q <= dat_d;
            blk_q <= blk_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;

endmodule

// File: tb/tb_wb_gcd_multi.sv
// tb_wb_gcd_multi: scoreboard bench for wb_gcd_multi. Bus tasks push the
// expected response of every access; a monitor pops on each ack.
module tb_wb_gcd_multi;

    localparam int          NCH  = 4;
    localparam logic [31:0] BASE = 32'h3000_0000;
`ifdef GCD_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'hF;
    logic [31:0] adr = '0, wdat = '0;
    logic        ack;
    logic [31:0] rdat;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit          chk;
        logic [31:0] val;
        string       name;
    } exp_t;
    exp_t exp_q[$];
    bit   prev_ack = 1'b0;

    always #5 clk = ~clk;

    wb_gcd_multi #(.WIDTH(32), .NCH(NCH), .BASE_ADDR(BASE)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wbs_stb_i  (stb),
        .wbs_cyc_i  (cyc),
        .wbs_we_i   (we),
        .wbs_sel_i  (sel),
        .wbs_adr_i  (adr),
        .wbs_dat_i  (wdat),
        .wbs_ack_o  (ack),
        .wbs_dat_o  (rdat),
        .user_irq_o (irq)
    );

    function automatic logic [31:0] gcd_ref(logic [31:0] a, logic [31:0] b);
        logic [31:0] t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic logic [31:0] ch_adr(int c, int r);
        return BASE + 32'(c * 16 + r);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: pop and compare on every ack; data must be zero outside ack
    exp_t ent;
    always @(negedge clk) begin
        if (!rst) begin
            if (ack) begin
                check("ack_single_cycle", 32'(prev_ack), 32'd0);
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_ack: got ack with no access outstanding at %0t", $time);
                end else begin
                    ent = exp_q.pop_front();
                    if (ent.chk) check(ent.name, rdat, ent.val);
                end
            end else begin
                check("dat_zero_outside_ack", rdat, 32'd0);
            end
        end
        prev_ack = ack;
    end

    task automatic bus(input logic [31:0] a, input logic w, input logic [31:0] d,
                       input bit chk, input logic [31:0] ev, input string name,
                       output logic [31:0] rd);
        exp_t e;
        int   lat;
        e.chk = chk; e.val = ev; e.name = name;
        exp_q.push_back(e);
        rd  = '0;
        lat = -1;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                lat = i;
                rd  = rdat;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        if (lat < 0) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: no ack within 8 cycles, expected ack after 1 cycle", name);
            void'(exp_q.pop_back());
        end else begin
            check({name, "_ack_latency"}, 32'(lat), 32'd0);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input string name);
        logic [31:0] dummy;
        bus(a, 1'b1, d, 1'b0, '0, name, dummy);
    endtask

    task automatic rd_chk(input logic [31:0] a, input logic [31:0] ev, input string name);
        logic [31:0] dummy;
        bus(a, 1'b0, '0, 1'b1, ev, name, dummy);
    endtask

    task automatic rd_raw(input logic [31:0] a, output logic [31:0] v);
        bus(a, 1'b0, '0, 1'b0, '0, "poll", v);
    endtask

    task automatic wait_done(input int c, input string name);
        logic [31:0] v;
        bit ok = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            rd_raw(ch_adr(c, 8), v);
            if (v[1]) begin
                ok = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: done bit never set, expected done=1", name);
        end
    endtask

    task automatic run_gcd(input int c, input logic [31:0] a, input logic [31:0] b, input string name);
        wr(ch_adr(c, 0), a, {name, "_opa"});
        wr(ch_adr(c, 4), b, {name, "_opb"});
        wr(ch_adr(c, 8), 32'd1, {name, "_start"});
        wait_done(c, name);
        rd_chk(ch_adr(c, 12), gcd_ref(a, b), {name, "_result"});
        rd_chk(ch_adr(c, 8), 32'd2, {name, "_ctrl_done"});
    endtask

    task automatic no_ack_window(input logic [31:0] a, input string name);
        int acks = 0;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (ack) acks++;
        end
        cyc = 1'b0; stb = 1'b0;
        check(name, 32'(acks), 32'd0);
    endtask

    initial begin
        #900_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] ea [NCH];
        logic [31:0] eb [NCH];
        int          acks;

        // Async reset: outputs must clear without a clock edge
        #1 rst = 1'b1;
        #1;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_dat", rdat, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);

        rd_chk(ch_adr(0, 0), 32'd0, "rst_opa0");
        rd_chk(ch_adr(0, 8), 32'd0, "rst_ctrl0");
        rd_chk(ch_adr(0, 12), 32'd0, "rst_res0");
        rd_chk(BASE + 32'h104, 32'd0, "rst_irq_stat");

        // Basic 48/18 with busy then done inside 10 cycles
        wr(ch_adr(0, 0), 32'd48, "c0_opa");
        wr(ch_adr(0, 4), 32'd18, "c0_opb");
        wr(ch_adr(0, 8), 32'd1, "c0_start");
        rd_chk(ch_adr(0, 8), 32'd1, "c0_busy");
        repeat (10) @(posedge clk);
        rd_chk(ch_adr(0, 8), 32'd2, "c0_done");
        rd_chk(ch_adr(0, 12), 32'd6, "c0_result_6");

        // Zero operand corners
        run_gcd(0, 32'd0, 32'd7, "gcd_0_7");
        run_gcd(0, 32'd0, 32'd0, "gcd_0_0");
        run_gcd(0, 32'd13, 32'd0, "gcd_13_0");

        // Two channels running concurrently
        wr(ch_adr(1, 0), 32'd1071, "c1_opa");
        wr(ch_adr(1, 4), 32'd462, "c1_opb");
        wr(ch_adr(3, 0), 32'd270, "c3_opa");
        wr(ch_adr(3, 4), 32'd192, "c3_opb");
        wr(ch_adr(1, 8), 32'd1, "c1_start");
        wr(ch_adr(3, 8), 32'd1, "c3_start");
        wait_done(1, "c1_wait");
        wait_done(3, "c3_wait");
        rd_chk(ch_adr(1, 12), 32'd21, "c1_result_21");
        rd_chk(ch_adr(3, 12), 32'd6, "c3_result_6");
        rd_chk(BASE + 32'h104, 32'hB, "irq_stat_c013");

        // Interrupt mask and W1C
        wr(BASE + 32'h100, 32'h2, "irq_mask_wr");
        rd_chk(BASE + 32'h100, IRQ_ON ? 32'h2 : 32'h0, "irq_mask_rd");
        wr(ch_adr(1, 8), 32'd1, "c1_restart");
        @(negedge clk);
        check("irq_low_during_calc", 32'(irq), 32'd0);
        wait_done(1, "c1_wait2");
        @(negedge clk);
        check("irq_after_c1_done", 32'(irq), IRQ_ON ? 32'd1 : 32'd0);
        wr(BASE + 32'h104, 32'h2, "irq_w1c_c1");
        @(negedge clk);
        check("irq_after_w1c", 32'(irq), 32'd0);
        rd_chk(BASE + 32'h104, 32'h9, "irq_stat_after_w1c");
        wr(BASE + 32'h104, 32'hF, "irq_w1c_all");
        rd_chk(BASE + 32'h104, 32'h0, "irq_stat_clear");
        rd_chk(ch_adr(0, 8), 32'd0, "c0_idle_after_w1c");

        // Unmapped and out-of-window accesses
        rd_chk(BASE + 32'h180, 32'd0, "unmapped_rd");
        wr(BASE + 32'h180, 32'hDEAD_BEEF, "unmapped_wr");
        rd_chk(BASE + 32'h180, 32'd0, "unmapped_rd2");
        rd_chk(ch_adr(NCH, 0), 32'd0, "absent_channel_rd");
        no_ack_window(BASE + 32'h200, "no_ack_above");
        no_ack_window(BASE - 32'h4, "no_ack_below");

        // Writes while busy are acked and ignored
        wr(ch_adr(2, 0), 32'd1071, "c2_opa");
        wr(ch_adr(2, 4), 32'd462, "c2_opb");
        wr(ch_adr(2, 8), 32'd1, "c2_start");
        wr(ch_adr(2, 0), 32'd99, "c2_opa_busy");
        wr(ch_adr(2, 8), 32'd1, "c2_start_busy");
        wait_done(2, "c2_wait");
        rd_chk(ch_adr(2, 12), gcd_ref(32'd1071, 32'd462), "c2_result_unchanged");
        rd_chk(ch_adr(2, 0), 32'd1071, "c2_opa_unchanged");

        // Randomized concurrent runs over all channels
        for (int it = 0; it < 10; it++) begin
            for (int c = 0; c < NCH; c++) begin
                ea[c] = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 600));
                eb[c] = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 600));
                wr(ch_adr(c, 0), ea[c], "rnd_opa");
                wr(ch_adr(c, 4), eb[c], "rnd_opb");
                wr(ch_adr(c, 8), 32'd1, "rnd_start");
            end
            for (int c = 0; c < NCH; c++) begin
                wait_done(c, "rnd_wait");
                rd_chk(ch_adr(c, 12), gcd_ref(ea[c], eb[c]), "rnd_result");
                rd_chk(ch_adr(c, 0), ea[c], "rnd_opa_rd");
                rd_chk(ch_adr(c, 4), eb[c], "rnd_opb_rd");
            end
            rd_chk(BASE + 32'h104, 32'hF, "rnd_irq_stat");
            wr(BASE + 32'h104, 32'hF, "rnd_w1c");
            rd_chk(BASE + 32'h104, 32'h0, "rnd_irq_stat_clr");
        end

        // Request held across reset release must not be acked
        @(posedge clk); #1;
        rst = 1'b1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = ch_adr(0, 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (ack) acks++;
        end
        cyc = 1'b0; stb = 1'b0;
        check("no_ack_pending_at_reset", 32'(acks), 32'd0);

        // Reset mid-calculation aborts without done
        wr(ch_adr(0, 0), 32'd65535, "long_opa");
        wr(ch_adr(0, 4), 32'd1, "long_opb");
        wr(ch_adr(0, 8), 32'd1, "long_start");
        rd_chk(ch_adr(0, 8), 32'd1, "long_busy");
        repeat (20) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midrst_ack", 32'(ack), 32'd0);
        check("midrst_dat", rdat, 32'd0);
        check("midrst_irq", 32'(irq), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        rd_chk(ch_adr(0, 8), 32'd0, "midrst_ctrl");
        rd_chk(ch_adr(0, 12), 32'd0, "midrst_result");
        rd_chk(ch_adr(0, 0), 32'd0, "midrst_opa");
        rd_chk(BASE + 32'h104, 32'd0, "midrst_irq_stat");

        repeat (3) @(posedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
